frame_stream_source: RTL

FRAME_STREAM_SOURCE -- requirements
Module: frame_stream_source

---
 rtl/frame_stream_source_pkg.sv | 15 +
 rtl/stream_skid_fifo.sv | 64 ++++++
 rtl/frame_stream_source.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/frame_stream_source_pkg.sv
// Shared state encoding and sizing constants for the frame stream source.
package frame_stream_source_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    STREAM,
    FLUSH
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int GAP_CYCLES = 2;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO between the frame-RAM read port and the pixel stream.
// Head data is visible combinationally; push is ignored when full, pop when empty.
module stream_skid_fifo
  import frame_stream_source_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == DEPTH);
  assign empty_o = (cnt_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Storage is cleared on reset so the stream data output reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_stream_source.sv
// Streams one frame from a 1-cycle-latency RAM into the scaler input, one pixel per cycle.
// FRAME_STREAM_SOURCE_GRAY_EN: RAM holds one channel, replicated into all channels of dIn.
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 3,
  parameter int X_RES_WIDTH = 11,
  parameter int Y_RES_WIDTH = 11,
  parameter int ADDR_WIDTH  = 20,
`ifdef FRAME_STREAM_SOURCE_GRAY_EN
  localparam int MEM_W = DATA_WIDTH
`else
  localparam int MEM_W = DATA_WIDTH * CHANNELS
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frameReq,
  input  logic [X_RES_WIDTH-1:0]         xRes,
  input  logic [Y_RES_WIDTH-1:0]         yRes,
  input  logic [ADDR_WIDTH-1:0]          baseAddr,
  output logic [ADDR_WIDTH-1:0]          memAddr,
  output logic                           memRd,
  input  logic [MEM_W-1:0]               memData,
  output logic                           start,
  output logic [DATA_WIDTH*CHANNELS-1:0] dIn,
  output logic                           dInValid,
  input  logic                           nextDin,
  output logic                           busy,
  output logic                           frameDone
);

  localparam int         CW       = X_RES_WIDTH + Y_RES_WIDTH;
  localparam logic [1:0] DEPTH    = 2'(FIFO_DEPTH);
  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [X_RES_WIDTH-1:0] x_q, x_d;
  logic [Y_RES_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CW-1:0]          rd_idx_q, rd_idx_d;
  logic [CW-1:0]          xf_idx_q, xf_idx_d;
  logic [CW-1:0]          last_idx;
  logic                   rd_done_q, rd_done_d;
  logic                   done_q, done_d;
  logic                   pend_q;
  logic [1:0]             gap_q, gap_d;
  logic [1:0]             used;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   credit_ok;
  logic [MEM_W-1:0]       head;

  // Index of the final pixel, (x+1)*(y+1)-1, which always fits in CW bits.
  assign last_idx = CW'(x_q) * CW'(y_q) + CW'(x_q) + CW'(y_q);

  assign used      = (fifo_full ? 2'd2 : {1'b0, !fifo_empty}) + {1'b0, pend_q};
  // A pixel leaving this cycle frees its slot in time for a read issued now.
  assign credit_ok = (used < DEPTH) || (pop && (used == DEPTH));

  assign memRd     = ((state_q == GAP) || (state_q == STREAM)) && !rd_done_q && credit_ok;
  assign memAddr   = addr_q;
  assign dInValid  = ((state_q == STREAM) || (state_q == FLUSH)) && !fifo_empty;
  assign pop       = dInValid && nextDin;
  assign start     = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign frameDone = done_q;

`ifdef FRAME_STREAM_SOURCE_GRAY_EN
  assign dIn = {CHANNELS{head}};
`else
  assign dIn = head;
`endif

  stream_skid_fifo #(
    .W (MEM_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (pend_q),
    .pop_i   (pop),
    .dat_i   (memData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    rd_idx_d  = rd_idx_q;
    xf_idx_d  = xf_idx_q;
    rd_done_d = rd_done_q;
    gap_d     = gap_q;
    done_d    = 1'b0;

    if (memRd) begin
      addr_d   = addr_q + ADDR_WIDTH'(1);
      rd_idx_d = rd_idx_q + CW'(1);
      if (rd_idx_q == last_idx) begin
        rd_done_d = 1'b1;
      end
    end
    if (pop) begin
      xf_idx_d = xf_idx_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (frameReq) begin
          state_d   = START;
          x_d       = xRes;
          y_d       = yRes;
          addr_d    = baseAddr;
          rd_idx_d  = '0;
          xf_idx_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      START: begin
        state_d = GAP;
        gap_d   = 2'd0;
      end
      GAP: begin
        gap_d = gap_q + 2'd1;
        if (gap_q == GAP_LAST) begin
          state_d = rd_done_d ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (rd_done_d) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // frameDone is raised while still busy so a same-cycle request is ignored.
        if (done_q) begin
          state_d = IDLE;
        end else if (pop && (xf_idx_q == last_idx)) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      rd_idx_q  <= '0;
      xf_idx_q  <= '0;
      rd_done_q <= 1'b0;
      done_q    <= 1'b0;
      gap_q     <= 2'd0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      rd_idx_q  <= rd_idx_d;
      xf_idx_q  <= xf_idx_d;
      rd_done_q <= rd_done_d;
      done_q    <= done_d;
      gap_q     <= gap_d;
      pend_q    <= memRd;
    end
  end

endmodule
